// File: rtl/trng_crngt_if.sv
// Collector-to-EHR bundle around the continuous RNG test stage.
// The master side is the collector/control side; the slave side is the CRNGT.
interface trng_crngt_if #(
  parameter int SAMPLE_W  = 16,
  parameter int ERR_CNT_W = 8
);
  logic                 collector_valid;
  logic [SAMPLE_W-1:0]  collector_data;
  logic                 trng_crngt_bypass;
  logic                 rst_trng_logic;
  logic                 accum_enough_bits;
  logic                 crngt_valid;
  logic [SAMPLE_W-1:0]  crngt_data;
  logic                 crngt_err;
  logic                 crngt_err_sticky;
  logic [ERR_CNT_W-1:0] crngt_err_cnt;

  modport master (
    output collector_valid, collector_data, trng_crngt_bypass,
           rst_trng_logic, accum_enough_bits,
    input  crngt_valid, crngt_data, crngt_err, crngt_err_sticky, crngt_err_cnt
  );

  modport slave (
    input  collector_valid, collector_data, trng_crngt_bypass,
           rst_trng_logic, accum_enough_bits,
    output crngt_valid, crngt_data, crngt_err, crngt_err_sticky, crngt_err_cnt
  );
endinterface

// File: rtl/trng_crngt.sv
// Continuous RNG test: forwards a sample only if it differs from the previous
// accepted one; a repeat latches FAIL until a soft or hard restart.
module trng_crngt #(
  parameter int SAMPLE_W  = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic         rng_clk,
  input  logic         rst_n,
  trng_crngt_if.slave  bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, PRIMED = 2'd1, FAIL = 2'd2} state_t;

  state_t               r_state, w_state_eff, w_state_nxt;
  logic [SAMPLE_W-1:0]  r_prev, r_data;
  logic                 r_valid, r_err, r_sticky, r_byp_q;
  logic [ERR_CNT_W-1:0] r_cnt;
  logic                 w_accept, w_pass, w_fail, w_load;

  always_comb begin
    // Leaving bypass re-primes from scratch, so the first sample is discarded.
    w_state_eff = (r_byp_q && !bus.trng_crngt_bypass && r_state == PRIMED) ? EMPTY : r_state;
    w_accept    = bus.collector_valid && !bus.accum_enough_bits &&
                  !bus.trng_crngt_bypass && (w_state_eff != FAIL);
    w_state_nxt = w_state_eff;
    w_pass      = 1'b0;
    w_fail      = 1'b0;
    w_load      = 1'b0;
    case (w_state_eff)
      EMPTY: if (w_accept) begin
        w_load      = 1'b1;
        w_state_nxt = PRIMED;
      end
      PRIMED: if (w_accept) begin
        if (bus.collector_data != r_prev) begin
          w_pass = 1'b1;
          w_load = 1'b1;
        end else begin
          w_fail      = 1'b1;
          w_state_nxt = FAIL;
        end
      end
      default: w_state_nxt = w_state_eff;
    endcase
    if (bus.rst_trng_logic) begin
      w_state_nxt = EMPTY;
      w_pass      = 1'b0;
      w_fail      = 1'b0;
      w_load      = 1'b0;
    end
  end

  always_ff @(posedge rng_clk) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_prev   <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
      r_byp_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_byp_q <= bus.trng_crngt_bypass;
      r_valid <= w_pass;
      r_err   <= w_fail;
      if (w_pass) r_data <= bus.collector_data;
      if (bus.rst_trng_logic) begin
        r_prev   <= '0;
        r_sticky <= 1'b0;
      end else begin
        if (w_load) r_prev <= bus.collector_data;
        if (w_fail) begin
          r_sticky <= 1'b1;
          if (r_cnt != {ERR_CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.crngt_valid      = r_valid;
  assign bus.crngt_data       = r_data;
  assign bus.crngt_err        = r_err;
  assign bus.crngt_err_sticky = r_sticky;
  assign bus.crngt_err_cnt    = r_cnt;
endmodule

// File: tb/tb_trng_crngt.sv
// Directed bench for trng_crngt: one 8-bit-counter instance for the main flow
// and one 2-bit-counter instance for saturation.
module tb_trng_crngt;
  logic clk = 1'b0;
  logic rst_na, rst_nb;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  trng_crngt_if #(.SAMPLE_W(16), .ERR_CNT_W(8)) ifa ();
  trng_crngt_if #(.SAMPLE_W(16), .ERR_CNT_W(2)) ifb ();

  trng_crngt #(.SAMPLE_W(16), .ERR_CNT_W(8)) dut_a (.rng_clk(clk), .rst_n(rst_na), .bus(ifa.slave));
  trng_crngt #(.SAMPLE_W(16), .ERR_CNT_W(2)) dut_b (.rng_clk(clk), .rst_n(rst_nb), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic stepa(input logic v, input logic [15:0] d, input logic byp,
                       input logic rt, input logic full);
    ifa.collector_valid   = v;
    ifa.collector_data    = d;
    ifa.trng_crngt_bypass = byp;
    ifa.rst_trng_logic    = rt;
    ifa.accum_enough_bits = full;
    @(posedge clk); #1;
  endtask

  task automatic stepb(input logic v, input logic [15:0] d, input logic rt);
    ifb.collector_valid   = v;
    ifb.collector_data    = d;
    ifb.trng_crngt_bypass = 1'b0;
    ifb.rst_trng_logic    = rt;
    ifb.accum_enough_bits = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chka(input string tag, input logic v, input logic [15:0] d,
                      input logic e, input logic s, input logic [7:0] c);
    chk({tag, ".valid"},  {31'd0, ifa.crngt_valid}, {31'd0, v});
    chk({tag, ".data"},   {16'd0, ifa.crngt_data}, {16'd0, d});
    chk({tag, ".err"},    {31'd0, ifa.crngt_err}, {31'd0, e});
    chk({tag, ".sticky"}, {31'd0, ifa.crngt_err_sticky}, {31'd0, s});
    chk({tag, ".cnt"},    {24'd0, ifa.crngt_err_cnt}, {24'd0, c});
  endtask

  initial begin
    rst_na = 1'b0;
    rst_nb = 1'b0;
    stepa(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    stepb(1'b0, 16'h0, 1'b0);
    chka("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0);
    rst_na = 1'b1;
    rst_nb = 1'b1;

    // First sample is only a reference; next two differ and are forwarded.
    stepa(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0); chka("first", 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0);
    stepa(1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0); chka("abcd",  1'b1, 16'hABCD, 1'b0, 1'b0, 8'd0);
    stepa(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0); chka("5555",  1'b1, 16'h5555, 1'b0, 1'b0, 8'd0);
    stepa(1'b0, 16'h9999, 1'b0, 1'b0, 1'b0); chka("hold",  1'b0, 16'h5555, 1'b0, 1'b0, 8'd0);

    // Repeat detection and FAIL lockout.
    stepa(1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0); chka("ff_a",  1'b1, 16'h00FF, 1'b0, 1'b0, 8'd0);
    stepa(1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0); chka("ff_rep", 1'b0, 16'h00FF, 1'b1, 1'b1, 8'd1);
    stepa(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0); chka("fail1", 1'b0, 16'h00FF, 1'b0, 1'b1, 8'd1);
    stepa(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0); chka("fail2", 1'b0, 16'h00FF, 1'b0, 1'b1, 8'd1);

    // Soft restart drops the same-cycle sample, clears sticky, keeps count.
    stepa(1'b1, 16'h0009, 1'b0, 1'b1, 1'b0); chka("rstt",  1'b0, 16'h00FF, 1'b0, 1'b0, 8'd1);
    stepa(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0); chka("p0001", 1'b0, 16'h00FF, 1'b0, 1'b0, 8'd1);
    stepa(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0); chka("p0002", 1'b1, 16'h0002, 1'b0, 0, 8'd1);

    // EHR full: repeat of prev is dropped, not compared.
    stepa(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0); chka("p7777", 1'b1, 16'h7777, 1'b0, 1'b0, 8'd1);
    stepa(1'b1, 16'h7777, 1'b0, 1'b0, 1'b1); chka("full1", 1'b0, 16'h7777, 1'b0, 1'b0, 8'd1);
    stepa(1'b1, 16'h7777, 1'b0, 1'b0, 1'b1); chka("full2", 1'b0, 16'h7777, 1'b0, 1'b0, 8'd1);
    stepa(1'b1, 16'h8888, 1'b0, 1'b0, 1'b0); chka("p8888", 1'b1, 16'h8888, 1'b0, 1'b0, 8'd1);

    // Bypass: no outputs; exit re-primes so 0xAAAA is discarded.
    for (int i = 0; i < 10; i++) begin
      stepa(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
      chk("byp.valid", {31'd0, ifa.crngt_valid}, 32'd0);
      chk("byp.err",   {31'd0, ifa.crngt_err}, 32'd0);
    end
    stepa(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0); chka("pbyp_a", 1'b0, 16'h8888, 1'b0, 1'b0, 8'd1);
    stepa(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0); chka("pbyp_b", 1'b1, 16'hBBBB, 1'b0, 1'b0, 8'd1);

    // Soft restart wins over a sample that would otherwise pass.
    stepa(1'b1, 16'hCCCC, 1'b0, 1'b1, 1'b0); chka("rst_pri", 1'b0, 16'hBBBB, 1'b0, 1'b0, 8'd1);

    // Hard reset clears the counter too.
    rst_na = 1'b0;
    stepa(1'b1, 16'hDDDD, 1'b0, 1'b0, 1'b0); chka("rst_a", 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0);
    rst_na = 1'b1;

    // 2-bit counter saturates at 3 while crngt_err keeps pulsing.
    for (int i = 0; i < 5; i++) begin
      stepb(1'b0, 16'h0, 1'b1);
      stepb(1'b1, 16'hC3C3, 1'b0);
      stepb(1'b1, 16'hC3C3, 1'b0);
      chk("sat.err",   {31'd0, ifb.crngt_err}, 32'd1);
      chk("sat.valid", {31'd0, ifb.crngt_valid}, 32'd0);
      chk("sat.cnt",   {30'd0, ifb.crngt_err_cnt}, (i < 3) ? i + 1 : 3);
    end
    rst_nb = 1'b0;
    stepb(1'b0, 16'h0, 1'b0);
    chk("rstb.valid",  {31'd0, ifb.crngt_valid}, 32'd0);
    chk("rstb.err",    {31'd0, ifb.crngt_err}, 32'd0);
    chk("rstb.sticky", {31'd0, ifb.crngt_err_sticky}, 32'd0);
    chk("rstb.cnt",    {30'd0, ifb.crngt_err_cnt}, 32'd0);
    chk("rstb.data",   {16'd0, ifb.crngt_data}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/trng_crngt.md
Name: trng_crngt

Overview:
- Continuous RNG test (CRNGT) stage directly upstream of the EHR bit-accounting logic.
- Takes 16-bit raw samples from the TRNG collector and compares each accepted sample with the previous one. An identical pair is a stuck-source failure.
- Good samples are registered and presented with a one-cycle crngt_valid pulse. The downstream stage adds 16 to its EHR bit count per pulse and treats crngt_err as the current-test error.

Parameters:
- SAMPLE_W, 16, collector sample width; must match the downstream per-pulse increment.
- ERR_CNT_W, 8, width of the saturating CRNGT failure counter.

Ports:
- rng_clk  input  1  TRNG clock; all state on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- collector_valid  input  1  collector_data valid this cycle.
- collector_data  input  SAMPLE_W  raw sample from collector.
- trng_crngt_bypass  input  1  CRNGT disabled; comparisons suppressed.
- rst_trng_logic  input  1  soft restart of TRNG datapath (synchronous).
- accum_enough_bits  input  1  EHR full; new samples must not be forwarded.
- crngt_valid  output  1  one-cycle pulse: crngt_data is a passed sample.
- crngt_data  output  SAMPLE_W  registered sample to EHR.
- crngt_err  output  1  one-cycle pulse on repeat detection.
- crngt_err_sticky  output  1  held high after a failure until restart.
- crngt_err_cnt  output  ERR_CNT_W  saturating count of failures since rst_n.

Behaviour:
- Reset (rst_n=0 at rising edge):
  - crngt_valid=0, crngt_err=0, crngt_err_sticky=0.
  - crngt_data=0, crngt_err_cnt=0, prev sample=0.
  - State moves to EMPTY.
- Accept condition: accept = collector_valid & !accum_enough_bits & !trng_crngt_bypass & state!=FAIL.
  - Samples that do not meet accept are dropped: no compare, prev unchanged, no output.
- State EMPTY, no reference held:
  - On accept, store the sample into prev and move to PRIMED.
  - The sample is not forwarded (FIPS first-block discard). crngt_valid stays 0.
- State PRIMED, on accept:
  - If sample != prev: next cycle crngt_valid=1 and crngt_data=sample; prev<=sample; state stays PRIMED.
  - If sample == prev: next cycle crngt_err=1 and crngt_err_sticky<=1. crngt_err_cnt increments, saturating at all-ones. crngt_valid=0. State moves to FAIL.
- State FAIL:
  - All samples are ignored.
  - crngt_err_sticky is held.
  - Exit only via rst_trng_logic or rst_n.
- Latency: exactly 1 cycle from accepted input to crngt_valid / crngt_err. Both outputs are registered and never asserted together.
- rst_trng_logic=1 at a rising edge:
  - State moves to EMPTY and prev is cleared.
  - crngt_valid, crngt_err and crngt_err_sticky are cleared that edge.
  - crngt_err_cnt is not cleared.
  - Any same-cycle sample is dropped.
  - rst_trng_logic has priority over all other events; rst_n has priority over rst_trng_logic.
- Bypass:
  - While trng_crngt_bypass=1, crngt_valid and crngt_err stay 0. The downstream stage counts collector_valid directly.
  - State and prev are frozen during bypass.
  - Deasserting bypass returns to EMPTY, so the first post-bypass sample is discarded.
- EHR full: with accum_enough_bits=1 and collector_valid=1, the sample is dropped. Holding prev keeps the compare chain over forwarded samples only.
- crngt_data holds its last value when crngt_valid=0.
- Counter saturation: at all-ones, further failures still pulse crngt_err, and the counter holds.
- Back-to-back: one accepted sample per cycle is supported at full rate. No internal buffering beyond the single output register.

Test Plan:
- Reset, then samples 0x1234, 0xABCD, 0x5555 on consecutive cycles -> no pulse for 0x1234. crngt_valid on cycles 3 and 4 with data 0xABCD then 0x5555. crngt_err never asserted.
- Primed with 0x00FF, then 0x00FF -> next cycle crngt_err=1 and crngt_valid=0. crngt_err_sticky=1, crngt_err_cnt=1. Further 0x1111 samples produce no output.
- From FAIL, pulse rst_trng_logic one cycle -> sticky=0, cnt stays 1. Samples 0x0001, 0x0002 -> only 0x0002 forwarded.
- accum_enough_bits=1 while feeding 0x7777 (prev=0x7777) -> no error, no valid. Deassert, feed 0x8888 -> crngt_valid with 0x8888.
- trng_crngt_bypass=1 with repeated 0xAAAA for 10 cycles -> crngt_valid=0 and crngt_err=0 throughout. Clear bypass, feed 0xAAAA, 0xBBBB -> only 0xBBBB forwarded.
- ERR_CNT_W=2: force 5 failures separated by rst_trng_logic -> 5 crngt_err pulses. cnt reads 1,2,3,3,3. rst_n low one edge -> all outputs 0.
